// File: rtl/refund_dispenser_pkg.sv
// Shared vending types: coin values, refund FSM states and the coin-select bundle.
package vend_pkg;

    localparam int unsigned QUARTER_C = 32'd25;
    localparam int unsigned DIME_C    = 32'd10;
    localparam int unsigned NICKEL_C  = 32'd5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        DISPENSE = 3'd2,
        GAP      = 3'd3,
        DONE     = 3'd4
    } refund_state_t;

    typedef struct packed {
        logic q;
        logic d;
        logic n;
    } coin_sel_t;

endpackage

// File: rtl/refund_dispenser_coin_select.sv
// Greedy single-coin picker: largest coin not exceeding the amount, plus what is left after it.
module coin_select
    import vend_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] i_remaining,
    output coin_sel_t    o_sel,
    output logic [W-1:0] o_next
);

    // Compare before subtracting so the amount can never wrap.
    always_comb begin
        o_sel  = '0;
        o_next = i_remaining;
        if (i_remaining >= W'(QUARTER_C)) begin
            o_sel.q = 1'b1;
            o_next  = i_remaining - W'(QUARTER_C);
        end else if (i_remaining >= W'(DIME_C)) begin
            o_sel.d = 1'b1;
            o_next  = i_remaining - W'(DIME_C);
        end else if (i_remaining >= W'(NICKEL_C)) begin
            o_sel.n = 1'b1;
            o_next  = i_remaining - W'(NICKEL_C);
        end else begin
            o_sel  = '0;
            o_next = i_remaining;
        end
    end

endmodule

// File: rtl/refund_dispenser.sv
// Refund FSM: on a refund-release edge, takes the held credit and pays it out
// greedily as spaced coin pulses, flagging any unpayable remainder.
module refund_dispenser
    import vend_pkg::*;
#(
    parameter int CREDIT_W   = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_trigger,
    input  logic [CREDIT_W-1:0] i_credit,
    output logic                o_clear_credit,
    output logic                o_coin_q,
    output logic                o_coin_d,
    output logic                o_coin_n,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_short_change
);

    localparam int CNT_W = $clog2(GAP_CYCLES + 1);

    refund_state_t       r_state;
    logic                r_trigger_prev;
    logic [CREDIT_W-1:0] r_remaining;
    logic [CNT_W-1:0]    r_gap_cnt;
    coin_sel_t           r_coin;
    logic                r_clear_credit;
    logic                r_busy;
    logic                r_done;
    logic                r_short_change;

    logic                w_trig_edge;
    logic [CREDIT_W-1:0] w_sel_in;
    coin_sel_t           w_sel;
    logic [CREDIT_W-1:0] w_next;

    assign w_trig_edge = i_trigger & ~r_trigger_prev;
    // During LOAD the picker looks at the incoming credit so the first coin can be registered for DISPENSE.
    assign w_sel_in    = (r_state == LOAD) ? i_credit : r_remaining;

    coin_select #(.W(CREDIT_W)) u_coin_select (
        .i_remaining (w_sel_in),
        .o_sel       (w_sel),
        .o_next      (w_next)
    );

    // Refund sequencer; every output is a register set on the transition into the cycle it marks.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_trigger_prev <= 1'b0;
            r_remaining    <= '0;
            r_gap_cnt      <= '0;
            r_coin         <= '0;
            r_clear_credit <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_short_change <= 1'b0;
        end else begin
            r_trigger_prev <= i_trigger;
            r_coin         <= '0;
            r_clear_credit <= 1'b0;
            r_done         <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_trig_edge) begin
                        r_state        <= LOAD;
                        r_short_change <= 1'b0;
                        r_clear_credit <= 1'b1;
                        r_busy         <= 1'b1;
                    end
                end
                LOAD: begin
                    r_remaining <= i_credit;
                    r_coin      <= w_sel;
                    r_state     <= DISPENSE;
                end
                DISPENSE: begin
                    r_remaining <= w_next;
                    if (w_sel.q | w_sel.d | w_sel.n) begin
                        r_state   <= GAP;
                        r_gap_cnt <= CNT_W'(GAP_CYCLES);
                    end else begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == CNT_W'(1)) begin
                        r_state <= DISPENSE;
                        r_coin  <= w_sel;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    r_short_change <= (r_remaining != '0);
                    r_remaining    <= '0;
                    r_busy         <= 1'b0;
                    r_state        <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_clear_credit = r_clear_credit;
    assign o_coin_q       = r_coin.q;
    assign o_coin_d       = r_coin.d;
    assign o_coin_n       = r_coin.n;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_short_change = r_short_change;

endmodule

// File: tb/tb_refund_dispenser.sv
// Self-checking bench: each refund is predicted from greedy change arithmetic and a cycle-offset timeline.
module tb_refund_dispenser;

    logic       i_clk;
    logic       i_reset;
    logic       i_trigger;
    logic [7:0] i_credit;
    logic       o_clear_credit;
    logic       o_coin_q;
    logic       o_coin_d;
    logic       o_coin_n;
    logic       o_busy;
    logic       o_done;
    logic       o_short_change;

    int total = 0;
    int bad   = 0;
    logic exp_short = 1'b0;

    refund_dispenser #(.CREDIT_W(8), .GAP_CYCLES(2)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_trigger      (i_trigger),
        .i_credit       (i_credit),
        .o_clear_credit (o_clear_credit),
        .o_coin_q       (o_coin_q),
        .o_coin_d       (o_coin_d),
        .o_coin_n       (o_coin_n),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_short_change (o_short_change)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Observed bundle: {clear, q, d, n, busy, done, short}
    function automatic logic [6:0] outs();
        return {o_clear_credit, o_coin_q, o_coin_d, o_coin_n, o_busy, o_done, o_short_change};
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Offset j counts clock edges after the cycle in which the trigger edge is presented.
    function automatic logic [6:0] expect_at(input int j, input int nq, input int nd,
                                             input int n, input logic sh);
        logic clr, q, d, nk, busy, done, s;
        int i;
        clr  = (j == 1);
        busy = (j >= 1) && (j <= 3 * n + 3);
        done = (j == 3 * n + 3);
        s    = (j == 3 * n + 4) ? sh : 1'b0;
        q = 1'b0; d = 1'b0; nk = 1'b0;
        if (j >= 2 && ((j - 2) % 3) == 0) begin
            i = (j - 2) / 3;
            if (i < nq)           q  = 1'b1;
            else if (i < nq + nd) d  = 1'b1;
            else if (i < n)       nk = 1'b1;
        end
        return {clr, q, d, nk, busy, done, s};
    endfunction

    // retrig_kind: 0 none, 1 fresh edge during dispensing, 2 fresh edge in the done cycle
    task automatic run_refund(input int credit, input int hold, input int retrig_kind,
                              input int abort_at, input int post);
        int nq, nd, nn, n, rem, last, retrig;
        logic sh;
        nq = credit / 25;
        rem = credit % 25;
        nd = rem / 10;
        rem = rem % 10;
        nn = rem / 5;
        rem = rem % 5;
        n = nq + nd + nn;
        sh = (rem != 0);
        last = 3 * n + 4;
        retrig = (retrig_kind == 1) ? hold + 2 : (retrig_kind == 2) ? 3 * n + 3 : -1;
        i_credit  = 8'(credit);
        i_trigger = 1'b1;
        for (int j = 1; j <= last; j++) begin
            tick();
            check($sformatf("c%0d_j%0d", credit, j), outs(), expect_at(j, nq, nd, n, sh));
            if (j == abort_at) begin
                i_trigger = 1'b0;
                i_reset   = 1'b1;
                tick();
                i_reset   = 1'b0;
                exp_short = 1'b0;
                check($sformatf("c%0d_reset_abort", credit), outs(), 7'b0);
                for (int k = 0; k < 8; k++) begin
                    tick();
                    check($sformatf("c%0d_after_abort%0d", credit, k), outs(), 7'b0);
                end
                return;
            end
            i_trigger = (j < hold) || (j == retrig);
            if (j >= 2) i_credit = 8'($urandom);
        end
        exp_short = sh;
        for (int j = last + 1; j <= last + post; j++) begin
            tick();
            check($sformatf("c%0d_post%0d", credit, j), outs(), {6'b0, exp_short});
            i_trigger = (j < hold);
        end
        i_trigger = 1'b0;
        tick();
        check($sformatf("c%0d_idle", credit), outs(), {6'b0, exp_short});
    endtask

    initial begin
        int c, h, rk, gap;
        i_reset   = 1'b1;
        i_trigger = 1'b0;
        i_credit  = 8'd0;
        repeat (3) tick();
        check("reset_state", outs(), 7'b0);
        i_reset = 1'b0;
        tick();
        check("idle_after_reset", outs(), 7'b0);

        run_refund(40, 2, 0, 0, 2);     // Q, D, N
        run_refund(0, 1, 0, 0, 2);      // no coins, done at offset 3
        run_refund(7, 1, 0, 0, 3);      // one nickel, short change held
        run_refund(255, 1, 1, 0, 2);    // 10Q + N, retrigger ignored; clears short
        run_refund(60, 1, 0, 2, 0);     // reset after the first quarter
        run_refund(60, 1, 0, 0, 2);     // Q, Q, D
        run_refund(13, 1, 2, 0, 3);     // edge in the done cycle is ignored

        // Trigger held high across reset release and for 20 cycles: one refund only.
        i_reset   = 1'b1;
        i_trigger = 1'b1;
        repeat (2) tick();
        check("reset_with_trigger", outs(), 7'b0);
        i_reset   = 1'b0;
        exp_short = 1'b0;
        run_refund(100, 20, 0, 0, 10);

        for (int it = 0; it < 25; it++) begin
            c   = int'($urandom_range(0, 255));
            h   = int'($urandom_range(1, 4));
            rk  = int'($urandom_range(0, 2));
            gap = int'($urandom_range(0, 3));
            run_refund(c, h, rk, 0, 1);
            for (int g = 0; g < gap; g++) begin
                tick();
                check($sformatf("rand%0d_gap%0d", it, g), outs(), {6'b0, exp_short});
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
